// File: rtl/flo_rr_arbiter144.sv
// flo_rr_arbiter144
//   Round-robin arbiter for 144 request lines. A snapshot of the request
//   vector is scanned by one shared 48-bit find-last-one, one slice per
//   cycle, from slice 2 down to slice 0.
//   pass0 only sees requesters below the last accepted grant. pass1 sees
//   the whole snapshot, which wraps the search back to the top.
//
// Ports
//   clk      in   system clock, all state on the rising edge
//   rst      in   synchronous active-high reset
//   req      in   [143:0] request lines, bit n = requester n
//   gnt_ack  in   consumer accepts the current grant
//   gnt_v    out  grant valid
//   gnt_idx  out  [7:0] granted index 0..143, 8'd255 when there is no grant
//   busy     out  high while scanning or granting
module flo_rr_arbiter144 (
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] req,
  input  logic         gnt_ack,
  output logic         gnt_v,
  output logic [7:0]   gnt_idx,
  output logic         busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_GRANT} state_t;

  state_t       state_q, state_d;
  logic [143:0] rq_q, rq_d;
  logic [7:0]   lg_q, lg_d;
  logic [1:0]   s_q, s_d;
  logic         pass_q, pass_d;
  logic         gnt_v_q, gnt_v_d;
  logic [7:0]   gnt_idx_q, gnt_idx_d;

  // Rotation mask: only indices strictly below the last accepted grant.
  // When lg is 255 ("none"), every index 0..143 passes.
  logic [143:0] mask;
  for (genvar gi = 0; gi < 144; gi++) begin : g_mask
    assign mask[gi] = (lg_q > 8'(gi));
  end

  logic [143:0] search;
  assign search = pass_q ? rq_q : (rq_q & mask);

  // Current 48-bit slice and the index of its lowest bit.
  logic [47:0] slice;
  logic [7:0]  slice_base;
  always_comb begin
    slice      = search[47:0];
    slice_base = 8'd0;
    case (s_q)
      2'd2: begin
        slice      = search[143:96];
        slice_base = 8'd96;
      end
      2'd1: begin
        slice      = search[95:48];
        slice_base = 8'd48;
      end
      default: begin
        slice      = search[47:0];
        slice_base = 8'd0;
      end
    endcase
  end

  // Shared find-last-one: the highest set bit wins because the loop
  // overwrites earlier (lower) hits.
  logic       f_hit;
  logic [5:0] f_idx;
  always_comb begin
    f_hit = 1'b0;
    f_idx = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (slice[i]) begin
        f_hit = 1'b1;
        f_idx = 6'(i);
      end
    end
  end

  logic [7:0] hit_idx;
  assign hit_idx = slice_base + {2'b00, f_idx};

  always_comb begin
    state_d   = state_q;
    rq_d      = rq_q;
    lg_d      = lg_q;
    s_d       = s_q;
    pass_d    = pass_q;
    gnt_v_d   = gnt_v_q;
    gnt_idx_d = gnt_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          rq_d    = req;
          pass_d  = 1'b0;
          s_d     = 2'd2;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (f_hit) begin
          gnt_idx_d = hit_idx;
          gnt_v_d   = 1'b1;
          state_d   = ST_GRANT;
        end else if (s_q != 2'd0) begin
          s_d = s_q - 2'd1;
        end else if (!pass_q) begin
          // pass0 exhausted: retry the whole snapshot from the top.
          pass_d = 1'b1;
          s_d    = 2'd2;
        end
      end
      ST_GRANT: begin
        if (gnt_ack) begin
          lg_d      = gnt_idx_q;
          gnt_v_d   = 1'b0;
          gnt_idx_d = 8'd255;
          state_d   = ST_IDLE;
        end else if (!req[gnt_idx_q]) begin
          // Requester withdrew before acceptance: drop without recording.
          gnt_v_d   = 1'b0;
          gnt_idx_d = 8'd255;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rq_q      <= '0;
      lg_q      <= 8'd255;
      s_q       <= 2'd2;
      pass_q    <= 1'b0;
      gnt_v_q   <= 1'b0;
      gnt_idx_q <= 8'd255;
    end else begin
      state_q   <= state_d;
      rq_q      <= rq_d;
      lg_q      <= lg_d;
      s_q       <= s_d;
      pass_q    <= pass_d;
      gnt_v_q   <= gnt_v_d;
      gnt_idx_q <= gnt_idx_d;
    end
  end

  assign gnt_v   = gnt_v_q;
  assign gnt_idx = gnt_idx_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: doc/flo_rr_arbiter144.md
# flo_rr_arbiter144

Round-robin arbiter for up to 144 request lines built around one time-shared 48-bit find-last-one slice. It snapshots the request vector and scans it one 48-bit slice per cycle, highest index first. The search starts below the last granted index, so every requester is served in turn. It drives a single grant with a valid/acknowledge handshake and sits in front of any shared resource the 144-bit priority encoder would otherwise pick for.

## Interface
- Parameters: none; width fixed at 144 requesters, 3 slices of 48.
- Ports:
  - clk  input  1  system clock, all state on rising edge
  - rst  input  1  synchronous, active-high reset
  - req  input  144  request lines, bit n = requester n
  - gnt_ack  input  1  consumer accepts current grant
  - gnt_v  output  1  grant valid
  - gnt_idx  output  8  granted index 0..143; 8'd255 when no grant
  - busy  output  1  high in SCAN or GRANT

## Operation
- Registers:
  - rq[143:0]: request snapshot.
  - lg[7:0]: last accepted grant, reset 8'd255, meaning "none".
  - s[1:0]: slice pointer, values 2, 1, 0.
  - pass: 1 bit.
  - state: IDLE, SCAN or GRANT.
- Slice s covers bits [48s+47:48s].
- Mask m[n] = (n < lg); with lg = 255 every bit passes.
- Search vector per cycle: pass0 uses rq & m, pass1 uses rq.
- One find-last-one per cycle on the current slice. The result f is 0..47, or "none".
- IDLE:
  - If req is nonzero: rq <= req, pass <= 0, s <= 2, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN:
  - Hit: gnt_idx <= 48s+f, gnt_v <= 1, go to GRANT.
  - Miss with s > 0: s <= s-1.
  - Miss with s = 0 and pass = 0: pass <= 1, s <= 2.
  - Pass1 always hits, because rq is nonzero.
- req changes during SCAN are ignored; the snapshot rules.
- GRANT, in priority order:
  - gnt_ack = 1: lg <= gnt_idx, gnt_v <= 0, gnt_idx <= 255, go to IDLE.
  - Otherwise, if req[gnt_idx] = 0 (withdrawn): gnt_v <= 0, gnt_idx <= 255, lg unchanged, go to IDLE.
  - Otherwise hold gnt_v and gnt_idx stable.
- Ack and withdraw in the same cycle count as an ack.
- gnt_ack outside GRANT is ignored.
- Fairness: after granting g, indices below g are preferred, descending, then the search wraps to the top. No requester waits more than 143 grants.

## Timing
- Reset values: state = IDLE, gnt_v = 0, gnt_idx = 8'd255, busy = 0, lg = 8'd255, rq = 0, s = 2, pass = 0.
- Reset in any state, including mid-scan or during GRANT with gnt_v high, returns to reset values on the next edge. No grant is issued or recorded.
- All outputs are registered. busy = (state != IDLE).
- Cycle 0: IDLE samples req. Cycle 1: first SCAN, slice 2, pass0.
- gnt_v rises at cycle 2 + k, where k = number of missed slices (0..5).
  - Best-case latency: 2 cycles.
  - Worst case: 7 cycles (pass1, slice 0).
- An ack in the first gnt_v cycle is accepted. gnt_v is low on the next cycle and state is IDLE.
- IDLE lasts at least one cycle after each grant. The minimum grant-to-grant spacing is 3 cycles.
- Withdrawal is detected combinationally from req in GRANT. gnt_v is low on the following cycle.

## Test plan
- Reset: assert rst 2 cycles mid-scan -> gnt_v = 0, gnt_idx = 255, busy = 0, lg = 255. A following single request still has latency 2.
- Single request req[100] = 1 from reset -> gnt_v = 1, gnt_idx = 100 at cycle 2. Ack -> lg = 100, gnt_v = 0 next cycle.
- Rotation: hold req[143] and req[5], ack every grant:
  - first grant 143, latency 2
  - then 5, latency 4
  - then 143, latency 5
  - sequence keeps alternating
- Wrap worst case: lg = 0, only req[0] = 1 -> pass0 misses all slices, grant 0 at latency 7.
- Withdrawal: req[60] granted with no ack, then req[60] dropped -> gnt_v = 0 and gnt_idx = 255 next cycle, lg unchanged. The same cycle with gnt_ack = 1 counts as an accept (lg = 60).
- Snapshot: grant of 47, then req = {bit 47, bit 20}, with bit 130 raised in cycle 1 of the scan -> grant 20 (bit 130 ignored). The next round grants 130.
